// File: rtl/uart_prog_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : uart_prog_loader
// Brief    : Loads the instruction memory from an 8N1 UART byte stream.
//            Optional trailing XOR checksum byte: define LOADER_CHECKSUM_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_prog_loader #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_WORDS    = 64,
    parameter int ADDR_W       = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              uart_rx,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              uart_done_reg,
    output logic              load_error
);

    localparam int                  c_TIMER_W   = $clog2(CLKS_PER_BIT);
    localparam logic [c_TIMER_W-1:0] c_HALF_END = c_TIMER_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_TIMER_W-1:0] c_BIT_END  = c_TIMER_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W:0]     c_LAST_WORD = (ADDR_W + 1)'(NUM_WORDS - 1);

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {
        LD_LOAD  = 2'd0,
        LD_CHECK = 2'd1,
        LD_DONE  = 2'd2,
        LD_LOCK  = 2'd3
    } ld_state_t;
`else
    typedef enum logic [0:0] {
        LD_LOAD = 1'b0,
        LD_DONE = 1'b1
    } ld_state_t;
`endif

    logic [1:0]           r_sync;
    rx_state_t            r_rx_state;
    logic [c_TIMER_W-1:0] r_timer;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_byte_valid;
    logic                 r_frame_err;

    ld_state_t            r_ld_state;
    logic [1:0]           r_byte_idx;
    logic [23:0]          r_asm;
    logic [ADDR_W:0]      r_word_cnt;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           r_xor;
`endif

    wire w_rx_s;
    assign w_rx_s = r_sync[1];

    // Receiver: the shift register doubles as the received byte, since it is
    // stable until the next data sample at least a bit and a half later.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync       <= 2'b11;
            r_rx_state   <= RX_IDLE;
            r_timer      <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_sync       <= {r_sync[0], uart_rx};
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    r_timer <= '0;
                    if (!w_rx_s) r_rx_state <= RX_START;
                end
                RX_START: begin
                    if (r_timer == c_HALF_END) begin
                        r_timer    <= '0;
                        r_bit_idx  <= '0;
                        r_rx_state <= w_rx_s ? RX_IDLE : RX_DATA;
                    end else begin
                        r_timer <= r_timer + c_TIMER_W'(1);
                    end
                end
                RX_DATA: begin
                    if (r_timer == c_BIT_END) begin
                        r_timer   <= '0;
                        r_shift   <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx <= r_bit_idx + 3'd1;
                        if (r_bit_idx == 3'd7) r_rx_state <= RX_STOP;
                    end else begin
                        r_timer <= r_timer + c_TIMER_W'(1);
                    end
                end
                RX_STOP: begin
                    if (r_timer == c_BIT_END) begin
                        r_timer    <= '0;
                        r_rx_state <= RX_IDLE;
                        if (w_rx_s) r_byte_valid <= 1'b1;
                        else        r_frame_err  <= 1'b1;
                    end else begin
                        r_timer <= r_timer + c_TIMER_W'(1);
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    // Word assembly: earlier bytes shift down so byte k lands in bits 8k+7:8k.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ld_state    <= LD_LOAD;
            r_byte_idx    <= '0;
            r_asm         <= '0;
            r_word_cnt    <= '0;
            imem_we       <= 1'b0;
            imem_addr     <= '0;
            imem_wdata    <= '0;
            uart_done_reg <= 1'b0;
            load_error    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            r_xor         <= '0;
`endif
        end else begin
            imem_we <= 1'b0;
            if (r_frame_err)            load_error    <= 1'b1;
            if (r_ld_state == LD_DONE)  uart_done_reg <= 1'b1;
            case (r_ld_state)
                LD_LOAD: begin
                    if (r_byte_valid) begin
                        r_asm      <= {r_shift, r_asm[23:8]};
                        r_byte_idx <= r_byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        r_xor      <= r_xor ^ r_shift;
`endif
                        if (r_byte_idx == 2'd3) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= r_word_cnt[ADDR_W-1:0];
                            imem_wdata <= {r_shift, r_asm};
                            r_word_cnt <= r_word_cnt + (ADDR_W + 1)'(1);
                            if (r_word_cnt == c_LAST_WORD) begin
`ifdef LOADER_CHECKSUM_EN
                                r_ld_state <= LD_CHECK;
`else
                                r_ld_state <= LD_DONE;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                LD_CHECK: begin
                    if (r_byte_valid) begin
                        if (r_shift == r_xor) begin
                            r_ld_state <= LD_DONE;
                        end else begin
                            load_error <= 1'b1;
                            r_ld_state <= LD_LOCK;
                        end
                    end
                end
`endif
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/uart_prog_loader.md
# uart_prog_loader

Serial program loader that fills the CPU core's 64-word instruction memory from a UART byte stream before execution starts. Receives 8N1 frames on `uart_rx`, packs four bytes little-endian into each 32-bit instruction word, writes words sequentially from address 0, and raises `uart_done_reg` once the image is complete. The core holds its PC at 0 until `uart_done_reg` is high.

## Interface
- `CLKS_PER_BIT`, 868, clk cycles per UART bit; legal minimum is 4.
- `NUM_WORDS`, 64, words per image; must be at most 2**`ADDR_W`.
- `ADDR_W`, 6, instruction memory word-address width.

- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-high reset.
- `uart_rx` in 1: serial input; idles high; asynchronous to `clk`.
- `imem_we` out 1: one-cycle write strobe to the instruction memory.
- `imem_addr` out `ADDR_W`: word address; valid while `imem_we` is high.
- `imem_wdata` out 32: instruction word; valid while `imem_we` is high.
- `uart_done_reg` out 1: image loaded; sticky until `rst`.
- `load_error` out 1: sticky error flag; stays high until `rst`.

## Operation
- **Reset values:** all outputs are 0. Byte index is 0, word count is 0, RX FSM is in IDLE, and the synchronizer flops reset to 1.
- **Input sync:** `uart_rx` passes through a 2-flop synchronizer. All references below are to the synchronized signal `rx_s`.
- **RX FSM, states IDLE, START, DATA, STOP:**
  - IDLE: move to START when `rx_s` is 0.
  - START: wait `CLKS_PER_BIT/2` cycles (integer division), then sample. If `rx_s` is 1, treat it as a glitch and return to IDLE with no error. If 0, go to DATA.
  - DATA: sample 8 bits, one every `CLKS_PER_BIT` cycles, LSB first, then go to STOP.
  - STOP: sample after `CLKS_PER_BIT` cycles. If 1, pulse the internal `byte_valid` for one cycle. If 0, it is a framing error: drop the byte and set `load_error`. Either way, return to IDLE in the same cycle.
- **Word assembly:**
  - Byte k (k = 0..3) is placed in `wdata[8k+7:8k]`.
  - On the 4th byte, `imem_we` is driven 1 for one cycle with `imem_addr` equal to the word count. The word count then increments and the byte index wraps to 0.
  - A framing error does not reset the byte index. The stream is corrupt at that point; `load_error` reports it.
- **Completion:** after write `NUM_WORDS-1`, the loader enters DONE (or CHECK when the checksum feature is enabled). In DONE:
  - `uart_done_reg` is 1.
  - All further bytes are received but ignored; no writes are issued.
- **Error lock:** a framing error does not block completion. `uart_done_reg` can be 1 while `load_error` is also 1.

## Timing
- **Frame latency:** from the first low `rx_s` to the `byte_valid` pulse is `CLKS_PER_BIT/2 + 9*CLKS_PER_BIT` cycles. Add 2 cycles measured from the raw `uart_rx` edge.
- **Write latency:** `imem_we` rises in the cycle after the 4th byte's `byte_valid`.
- **Done latency:** `uart_done_reg` rises in the cycle after the final `imem_we`. It rises in the cycle after checksum acceptance when `LOADER_CHECKSUM_EN` is defined.
- **Back-to-back frames:** a start bit arriving immediately after a stop sample is accepted, because the FSM returns to IDLE in the stop-sample cycle.
- **Reset mid-frame or mid-image:** all state is cleared and partial words are discarded. The next image starts at address 0.
- **Counters:** the bit-timer width is clog2(`CLKS_PER_BIT`). The word counter is `ADDR_W`+1 bits, so `NUM_WORDS` = 2**`ADDR_W` does not wrap.

## Configuration
- **`LOADER_CHECKSUM_EN` defined:**
  - One extra byte follows the image.
  - The loader keeps a running XOR of all 4*`NUM_WORDS` image bytes.
  - In CHECK, the next valid byte is compared with the running XOR:
    - Match: enter DONE and set `uart_done_reg` to 1.
    - Mismatch: set `load_error` to 1, keep `uart_done_reg` at 0, and enter LOCK. LOCK ignores all input until `rst`.
  - The memory writes already issued are not undone.
- **`LOADER_CHECKSUM_EN` undefined:**
  - There is no CHECK state and no XOR register.
  - DONE follows the last write directly.
  - `load_error` reports framing errors only.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `NUM_WORDS`=2.
- **Nominal load:** bytes 13 00 00 00 93 00 10 00 -> `imem_we` pulses at addr 0 with 0x00000013 and at addr 1 with 0x00100093. `uart_done_reg` rises 1 cycle after the second pulse; `load_error` stays 0.
- **Start glitch:** a 5-cycle low pulse on `uart_rx`, then a nominal load -> no byte is produced by the glitch, and the writes match the nominal case.
- **Framing error:** byte 0x13 sent with stop bit 0 -> no `byte_valid`, and `load_error` goes to 1 and stays 1.
- **Reset mid-image:** `rst` asserted after 6 bytes, then 8 new bytes -> writes restart at addr 0 with the new data, and all outputs read 0 during `rst`.
- **Post-done bytes:** 4 extra bytes after `uart_done_reg` is 1 -> no `imem_we` pulse, and `uart_done_reg` stays 1.
- **Checksum (`LOADER_CHECKSUM_EN` defined):** the nominal image followed by checksum byte 0x90 -> `uart_done_reg` is 1. The same image followed by 0x91 -> `load_error` is 1, `uart_done_reg` stays 0, and later bytes are ignored.
